// File: rtl/stripes_weight_serializer.sv
// Stripes weight serializer: parallel weight vector in, MSB-first bit lanes out.
// Double-buffered (shadow + active) so back-to-back vectors stream without bubbles.
module stripes_weight_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  input  logic w_valid,
  input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in,
  output logic w_ready,
  output logic [VEC_LENGTH-1:0] w_bit,
  output logic is_msb,
  output logic delayed_is_msb,
  output logic mac_en,
  output logic result_valid
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] shadow_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] active_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] shifted;
  logic                                  shadow_full;
  logic [0:0]                            state_q;
  logic [IW-1:0]                         bit_idx;
  logic                                  drain_q;
  logic                                  rv1_q;
  logic                                  rv2_q;
  logic                                  dmsb_q;

  logic in_shift;
  logic last_bit;
  logic transfer;
  logic accept;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (bit_idx == '0);
  assign transfer = !stall && shadow_full
                 && (!in_shift || last_bit);
  assign w_ready  = !shadow_full || transfer;
  assign accept   = w_valid && w_ready;

  assign is_msb         = in_shift && (bit_idx == IDX_TOP);
  assign delayed_is_msb = dmsb_q;
  assign mac_en         = !stall && (in_shift || drain_q);
  // Held pulse is released only on an enabled cycle, so a stall never stretches it.
  assign result_valid   = rv2_q && !stall;

  // Lane MSB taps and next-cycle shifted lanes.
  always_comb begin
    w_bit   = '0;
    shifted = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_bit[j]   = in_shift & active_q[j][DATA_WIDTH-1];
      shifted[j] = active_q[j] << 1;
    end
  end

  // Shadow buffer: accepts whenever empty or draining into the active register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q    <= '0;
      shadow_full <= 1'b0;
    end else if (clear) begin
      shadow_q    <= '0;
      shadow_full <= 1'b0;
    end else if (accept) begin
      shadow_q    <= w_in;
      shadow_full <= 1'b1;
    end else if (transfer) begin
      shadow_full <= 1'b0;
    end
  end

  // Serializer FSM: load from shadow, shift MSB first, reload on last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      bit_idx  <= IDX_TOP;
    end else if (clear) begin
      state_q  <= IDLE;
      active_q <= '0;
      bit_idx  <= IDX_TOP;
    end else if (!stall) begin
      if (transfer) begin
        state_q  <= SHIFT;
        active_q <= shadow_q;
        bit_idx  <= IDX_TOP;
      end else if (in_shift) begin
        active_q <= shifted;
        if (last_bit) begin
          state_q <= IDLE;
          bit_idx <= IDX_TOP;
        end else begin
          bit_idx <= bit_idx - 1'b1;
        end
      end
    end
  end

  // Delayed MSB flag, drain cycle and the two-stage result pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmsb_q  <= 1'b0;
      drain_q <= 1'b0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
    end else if (clear) begin
      dmsb_q  <= 1'b0;
      drain_q <= 1'b0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
    end else if (!stall) begin
      dmsb_q  <= is_msb;
      drain_q <= last_bit && !shadow_full;
      rv1_q   <= last_bit;
      rv2_q   <= rv1_q;
    end
  end

endmodule

// File: tb/tb_stripes_weight_serializer.sv
// Directed bench for stripes_weight_serializer.
// Table vectors plus hand sequences for streaming, clear and async reset.
module tb_stripes_weight_serializer;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic stall;
  logic w_valid;
  logic signed [15:0][7:0] w_in;
  logic w_ready;
  logic [15:0] w_bit;
  logic is_msb;
  logic delayed_is_msb;
  logic mac_en;
  logic result_valid;

  int checks = 0;
  int errors = 0;

  stripes_weight_serializer #(
    .DATA_WIDTH(8),
    .VEC_LENGTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .stall(stall),
    .w_valid(w_valid),
    .w_in(w_in),
    .w_ready(w_ready),
    .w_bit(w_bit),
    .is_msb(is_msb),
    .delayed_is_msb(delayed_is_msb),
    .mac_en(mac_en),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       st;
    logic       cl;
    logic [7:0] d;
    logic       rdy;
    logic       b0;
    logic       msb;
    logic       dmsb;
    logic       mac;
    logic       rv;
  } row_t;

  row_t tbl[29];

  function automatic row_t r(logic v, logic st, logic cl,
                             logic [7:0] d, logic rdy, logic b0,
                             logic msb, logic dmsb, logic mac,
                             logic rv);
    row_t x;
    x.v = v; x.st = st; x.cl = cl; x.d = d;
    x.rdy = rdy; x.b0 = b0; x.msb = msb;
    x.dmsb = dmsb; x.mac = mac; x.rv = rv;
    return x;
  endfunction

  function automatic logic [20:0] pk();
    return {w_ready, w_bit, is_msb, delayed_is_msb,
            mac_en, result_valid};
  endfunction

  function automatic logic [20:0] ex(logic rdy, logic [15:0] wb,
                                     logic m, logic dm,
                                     logic mac, logic rv);
    return {rdy, wb, m, dm, mac, rv};
  endfunction

  task automatic chk(input string name, input logic [20:0] act,
                     input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic st, input logic cl,
                     input logic [7:0] d0, input logic [7:0] d15);
    @(posedge clk);
    #1;
    w_valid = v;
    stall   = st;
    clear   = cl;
    w_in    = '0;
    w_in[0]  = d0;
    w_in[15] = d15;
    @(negedge clk);
  endtask

  logic [7:0] vec [3];
  int k;
  logic sh;
  logic eb;
  logic erdy;
  logic emsb;
  logic edm;
  logic emac;
  logic erv;
  int p;

  initial begin
    // single vector 0x83
    tbl[0]  = r(1,0,0,8'h83, 1,0,0,0,0,0);
    tbl[1]  = r(0,0,0,8'h00, 1,0,0,0,0,0);
    tbl[2]  = r(0,0,0,8'h00, 1,1,1,0,1,0);
    tbl[3]  = r(0,0,0,8'h00, 1,0,0,1,1,0);
    tbl[4]  = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[5]  = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[6]  = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[7]  = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[8]  = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[9]  = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[10] = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[11] = r(0,0,0,8'h00, 1,0,0,0,0,1);
    tbl[12] = r(0,0,0,8'h00, 1,0,0,0,0,0);
    // single vector 0xB6, stall 3 cycles at bit 4
    tbl[13] = r(1,0,0,8'hB6, 1,0,0,0,0,0);
    tbl[14] = r(0,0,0,8'h00, 1,0,0,0,0,0);
    tbl[15] = r(0,0,0,8'h00, 1,1,1,0,1,0);
    tbl[16] = r(0,0,0,8'h00, 1,0,0,1,1,0);
    tbl[17] = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[18] = r(0,1,0,8'h00, 1,1,0,0,0,0);
    tbl[19] = r(0,1,0,8'h00, 1,1,0,0,0,0);
    tbl[20] = r(0,1,0,8'h00, 1,1,0,0,0,0);
    tbl[21] = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[22] = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[23] = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[24] = r(0,0,0,8'h00, 1,1,0,0,1,0);
    tbl[25] = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[26] = r(0,0,0,8'h00, 1,0,0,0,1,0);
    tbl[27] = r(0,0,0,8'h00, 1,0,0,0,0,1);
    tbl[28] = r(0,0,0,8'h00, 1,0,0,0,0,0);

    reset = 1'b0;
    clear = 1'b0;
    stall = 1'b0;
    w_valid = 1'b0;
    w_in = '0;
    #2;
    chk("reset_outputs", pk(), ex(1,16'h0,0,0,0,0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      cyc(tbl[i].v, tbl[i].st, tbl[i].cl, tbl[i].d, 8'h00);
      chk($sformatf("tbl[%0d]", i), pk(),
          ex(tbl[i].rdy, {15'h0, tbl[i].b0}, tbl[i].msb,
             tbl[i].dmsb, tbl[i].mac, tbl[i].rv));
    end

    // back-to-back: three vectors, lane15 carries the inverse
    vec[0] = 8'h81;
    vec[1] = 8'h5A;
    vec[2] = 8'hC3;
    k = 0;
    for (int c = 0; c < 29; c++) begin
      if (k < 3) cyc(1'b1, 1'b0, 1'b0, vec[k], ~vec[k]);
      else       cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sh = (c >= 2) && (c <= 25);
      p  = c - 2;
      eb = 1'b0;
      emsb = 1'b0;
      if (sh) begin
        eb   = vec[p / 8][7 - (p % 8)];
        emsb = ((p % 8) == 0);
      end
      edm  = (c >= 3) && (c <= 26) && (((c - 3) % 8) == 0);
      erdy = !(((c >= 2) && (c <= 8)) || ((c >= 10) && (c <= 16)));
      emac = (c >= 2) && (c <= 26);
      erv  = (c == 11) || (c == 19) || (c == 27);
      chk($sformatf("b2b[%0d]", c), pk(),
          ex(erdy, {sh & ~eb, 14'h0, eb}, emsb, edm, emac, erv));
      if (w_valid && w_ready) k++;
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d expected 3", k);
    end

    // clear with a shadow vector pending, stall and w_valid also high
    cyc(1, 0, 0, 8'h91, 8'h00);
    cyc(1, 0, 0, 8'h22, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00);
    chk("clr_pre_msb", pk(), ex(0,16'h0001,1,0,1,0));
    cyc(0, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 1, 8'h33, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00);
    chk("clr_next", pk(), ex(1,16'h0,0,0,0,0));
    for (int c = 0; c < 14; c++) begin
      cyc(0, 0, 0, 8'h00, 8'h00);
      chk($sformatf("clr_quiet[%0d]", c), pk(),
          ex(1,16'h0,0,0,0,0));
    end

    // async reset mid-vector at bit_idx 2
    cyc(1, 0, 0, 8'hB6, 8'h00);
    for (int c = 1; c < 8; c++) cyc(0, 0, 0, 8'h00, 8'h00);
    chk("rst_pre_bit2", pk(), ex(1,16'h0001,0,0,1,0));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", pk(), ex(1,16'h0,0,0,0,0));
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, 8'h00, 8'h00);
      chk($sformatf("rst_quiet[%0d]", c), pk(),
          ex(1,16'h0,0,0,0,0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stripes_weight_serializer.md
STRIPES_WEIGHT_SERIALIZER -- requirements
Module: stripes_weight_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: weight precision and bit-serial cycles per vector.
REQ-002 SHALL have parameter VEC_LENGTH, default 16: number of weight lanes, matching the downstream Stripes MAC.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port clear, input, 1: synchronous abort, active-high.
REQ-006 SHALL have port stall, input, 1: freezes serialization while high.
REQ-007 SHALL have port w_valid, input, 1: weight vector offered.
REQ-008 SHALL have port w_in, input, VEC_LENGTH x DATA_WIDTH signed: parallel weight vector.
REQ-009 SHALL have port w_ready, output, 1: vector accepted when w_valid && w_ready at a rising edge.
REQ-010 SHALL have port w_bit, output, VEC_LENGTH x 1: current weight bit per lane, MSB first.
REQ-011 SHALL have port is_msb, output, 1: w_bit holds bit DATA_WIDTH-1 this cycle.
REQ-012 SHALL have port delayed_is_msb, output, 1: is_msb registered one enabled cycle later.
REQ-013 SHALL have port mac_en, output, 1: enable for the downstream MAC.
REQ-014 SHALL have port result_valid, output, 1: one-cycle pulse; downstream result is final.

Function
REQ-015 SHALL hold one shadow register (w_in copy plus shadow_full flag) and one active shift register per lane plus a bit counter bit_idx.
REQ-016 SHALL drive w_ready = !shadow_full || transfer, where transfer is the cycle the shadow moves into the active register.
REQ-017 SHALL implement states IDLE (active empty) and SHIFT (active serializing).
REQ-018 IDLE: if shadow_full && !stall, transfer shadow to active at next edge, bit_idx <= DATA_WIDTH-1, go to SHIFT.
REQ-019 SHIFT with !stall: shift each lane left by one, bit_idx decrements; at bit_idx==0 transfer the shadow if shadow_full and stay in SHIFT with bit_idx <= DATA_WIDTH-1, else go to IDLE.
REQ-020 SHALL drive w_bit[j] = MSB of lane j active register while in SHIFT, else 0.
REQ-021 SHALL drive is_msb = SHIFT && bit_idx==DATA_WIDTH-1.
REQ-022 SHALL drive mac_en = !stall && (SHIFT || drain), where drain is high for the single enabled cycle after the last bit of a vector with no next vector following.
REQ-023 SHALL pulse result_valid for one cycle, two enabled cycles after the cycle where bit_idx==0, covering the MAC psum register plus the accumulator.
REQ-024 SHALL stream back-to-back vectors with no bubble: sustained throughput one vector per DATA_WIDTH cycles.
REQ-025 Latency: a vector accepted at edge N from IDLE with the shadow empty SHALL present its MSB (is_msb=1) in the cycle following edge N+1.
REQ-026 While stall=1, SHALL hold bit_idx, the active registers, state, delayed_is_msb, and the result_valid pipeline. The shadow SHALL still accept when empty.
REQ-027 Simultaneous accept and transfer SHALL load the new w_in into the shadow and keep shadow_full=1.
REQ-028 clear=1 SHALL empty the shadow and active registers, go to IDLE, zero all outputs next cycle, and suppress pending result_valid pulses; clear has priority over stall and w_valid.
REQ-029 No arithmetic widening: weights are passed bit-exact; sign handling is by is_msb downstream.

Reset
REQ-030 While reset=0, SHALL asynchronously force IDLE, shadow_full=0, bit_idx=DATA_WIDTH-1, and all registers 0.
REQ-031 While reset=0, SHALL drive w_ready=1 and w_bit, is_msb, delayed_is_msb, mac_en, result_valid = 0.
REQ-032 Reset asserted mid-vector SHALL discard the vector with no result_valid pulse after release.

Verification
REQ-033 Single vector: lane0=8'sb1000_0011, others 0, accept at edge 0 -> lane0 w_bit sequence 1,0,0,0,0,0,1,1 over cycles 2..9; is_msb=1 only in cycle 2; delayed_is_msb=1 only in cycle 3; result_valid in cycle 11.
REQ-034 Back-to-back: three vectors, w_valid held high -> 24 consecutive SHIFT cycles, is_msb every 8th cycle, three result_valid pulses 8 cycles apart, w_ready low only while the shadow is full and no transfer occurs.
REQ-035 Stall: stall=1 for 3 cycles at bit_idx=4 -> w_bit holds, mac_en=0, and the sequence resumes at bit 4 with the result_valid pulse delayed 3 cycles.
REQ-036 Clear with a shadow vector pending mid-SHIFT -> next cycle all outputs 0, w_ready=1, no result_valid.
REQ-037 Async reset: drop reset between clock edges at bit_idx=2 -> outputs 0 immediately with no clock edge; after release, IDLE with w_ready=1.
